iopad_lane_tx: RTL and testbench

- Near-side pad transmitter. Accepts full-width words over a valid/ready handshake and drives only the lanes selected by `VALID_BITS` onto the `MAX_WIDTH` near-side tx pad bus.
- Each word is held on the pads for a fixed number of cycles. Lane output-enables are released through a turnaround gap before the next burst.
- Sits between the core-side data source and the pad ring. It is the driving counterpart of the far-side rx pad coupling.

---
 rtl/iopad_pkg.sv | 18 +
 rtl/iopad_cycle_counter.sv | 30 +++
 rtl/iopad_lane_tx.sv | 138 +++++++++++++
 tb/tb_iopad_lane_tx.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/iopad_pkg.sv
// Shared types and helpers for the near-side pad transmit lane.
package iopad_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    TURN
  } tx_state_t;

  // All-ones lane mask, truncated by the user to the pad bus width.
  localparam logic [63:0] DEFAULT_LANE_MASK = '1;

  // Bits needed to hold max_val in a down-counter, never less than one.
  function automatic int cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/iopad_cycle_counter.sv
// Loadable down-counter with a zero flag, used for hold and turnaround timing.
module iopad_cycle_counter
  import iopad_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  // Load wins over decrement so a back-to-back reload on the last cycle is clean.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/iopad_lane_tx.sv
// Near-side pad transmitter: holds each accepted word on the enabled lanes,
// then releases the output enables through a turnaround gap.
module iopad_lane_tx
  import iopad_pkg::*;
#(
  parameter int                   MAX_WIDTH   = 24,
  parameter logic [MAX_WIDTH-1:0] VALID_BITS  = MAX_WIDTH'(DEFAULT_LANE_MASK),
  parameter int                   HOLD_CYCLES = 2,
  parameter int                   TURN_CYCLES = 1,
  parameter logic [MAX_WIDTH-1:0] IDLE_VALUE  = '0,
  parameter int                   CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_enable,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [MAX_WIDTH-1:0] s_data,
  output logic [MAX_WIDTH-1:0] iopad_ns_tx_out,
  output logic [MAX_WIDTH-1:0] iopad_ns_tx_oe,
  output logic                 tx_busy,
  output logic [CNT_WIDTH-1:0] sent_count
);

  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("iopad_lane_tx: HOLD_CYCLES must be >= 1");
  end
  if (TURN_CYCLES < 0) begin : g_bad_turn
    $error("iopad_lane_tx: TURN_CYCLES must be >= 0");
  end

  localparam int HOLD_W = cnt_w(HOLD_CYCLES - 1);
  localparam int TURN_W = cnt_w((TURN_CYCLES > 0) ? TURN_CYCLES - 1 : 0);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [TURN_W-1:0] TURN_LOAD = TURN_W'((TURN_CYCLES > 0) ? TURN_CYCLES - 1 : 0);
  localparam bit HAS_TURN = (TURN_CYCLES > 0);
  localparam logic [MAX_WIDTH-1:0] FIXED_LANES = IDLE_VALUE & ~VALID_BITS;

  tx_state_t state, next_state;
  logic hold_load, hold_dec, hold_zero;
  logic turn_load, turn_dec, turn_zero;
  logic capture, count_inc;

  iopad_cycle_counter #(.WIDTH(HOLD_W)) u_hold (
    .clk        (clk),
    .rst        (rst),
    .load       (hold_load),
    .load_value (HOLD_LOAD),
    .dec        (hold_dec),
    .zero       (hold_zero)
  );

  iopad_cycle_counter #(.WIDTH(TURN_W)) u_turn (
    .clk        (clk),
    .rst        (rst),
    .load       (turn_load),
    .load_value (TURN_LOAD),
    .dec        (turn_dec),
    .zero       (turn_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    s_ready    = 1'b0;
    capture    = 1'b0;
    count_inc  = 1'b0;
    hold_load  = 1'b0;
    hold_dec   = 1'b0;
    turn_load  = 1'b0;
    turn_dec   = 1'b0;
    case (state)
      IDLE: begin
        s_ready = tx_enable;
        if (s_valid && tx_enable) begin
          capture    = 1'b1;
          hold_load  = 1'b1;
          next_state = DRIVE;
        end
      end
      DRIVE: begin
        if (hold_zero) begin
          // Last hold cycle: the word is done, and a new one may follow with no gap.
          count_inc = 1'b1;
          s_ready   = tx_enable;
          if (s_valid && tx_enable) begin
            capture   = 1'b1;
            hold_load = 1'b1;
          end else if (HAS_TURN) begin
            turn_load  = 1'b1;
            next_state = TURN;
          end else begin
            next_state = IDLE;
          end
        end else begin
          hold_dec = 1'b1;
        end
      end
      TURN: begin
        if (turn_zero) begin
          next_state = IDLE;
        end else begin
          turn_dec = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Pad outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iopad_ns_tx_out <= IDLE_VALUE;
      iopad_ns_tx_oe  <= '0;
      tx_busy         <= 1'b0;
      sent_count      <= '0;
    end else begin
      if (capture) begin
        iopad_ns_tx_out <= (s_data & VALID_BITS) | FIXED_LANES;
      end else if (next_state != DRIVE) begin
        iopad_ns_tx_out <= IDLE_VALUE;
      end
      iopad_ns_tx_oe <= (next_state == DRIVE) ? VALID_BITS : '0;
      tx_busy        <= (next_state != IDLE);
      if (count_inc) begin
        sent_count <= sent_count + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_iopad_lane_tx.sv
// Directed bench for iopad_lane_tx: three lane-mask variants share one input stream,
// and a fourth instance covers single-cycle hold with no turnaround.
module tb_iopad_lane_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        tx_enable;
  logic        s_valid;
  logic [23:0] s_data;
  logic        s_valid_d;
  logic [23:0] s_data_d;

  logic        ready_a, ready_b, ready_c, ready_d;
  logic        busy_a, busy_b, busy_c, busy_d;
  logic [23:0] out_a, out_b, out_c, out_d;
  logic [23:0] oe_a, oe_b, oe_c, oe_d;
  logic [15:0] cnt_a, cnt_b, cnt_d;
  logic [3:0]  cnt_c;

  int error_count = 0;
  int check_count = 0;

  always #5 clk = ~clk;

  iopad_lane_tx #(.VALID_BITS(24'h000100)) u_a (
    .clk(clk), .rst(rst), .tx_enable(tx_enable), .s_valid(s_valid), .s_ready(ready_a),
    .s_data(s_data), .iopad_ns_tx_out(out_a), .iopad_ns_tx_oe(oe_a), .tx_busy(busy_a),
    .sent_count(cnt_a)
  );

  iopad_lane_tx u_b (
    .clk(clk), .rst(rst), .tx_enable(tx_enable), .s_valid(s_valid), .s_ready(ready_b),
    .s_data(s_data), .iopad_ns_tx_out(out_b), .iopad_ns_tx_oe(oe_b), .tx_busy(busy_b),
    .sent_count(cnt_b)
  );

  iopad_lane_tx #(.VALID_BITS(24'h00FF00), .IDLE_VALUE(24'h0000FF), .CNT_WIDTH(4)) u_c (
    .clk(clk), .rst(rst), .tx_enable(tx_enable), .s_valid(s_valid), .s_ready(ready_c),
    .s_data(s_data), .iopad_ns_tx_out(out_c), .iopad_ns_tx_oe(oe_c), .tx_busy(busy_c),
    .sent_count(cnt_c)
  );

  iopad_lane_tx #(.HOLD_CYCLES(1), .TURN_CYCLES(0)) u_d (
    .clk(clk), .rst(rst), .tx_enable(tx_enable), .s_valid(s_valid_d), .s_ready(ready_d),
    .s_data(s_data_d), .iopad_ns_tx_out(out_d), .iopad_ns_tx_oe(oe_d), .tx_busy(busy_d),
    .sent_count(cnt_d)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got !== exp) begin
      error_count++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic valid, input logic [23:0] data);
    tx_enable = en;
    s_valid   = valid;
    s_data    = data;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Expected pads of the three shared-input instances for a word being driven or not.
  task automatic checkPads(input string tag, input logic [23:0] word, input bit drive);
    logic [23:0] ea, eb, ec;
    ea = drive ? (word & 24'h000100) : 24'h000000;
    eb = drive ? word : 24'h000000;
    ec = drive ? ((word & 24'h00FF00) | 24'h0000FF) : 24'h0000FF;
    checkOutput({tag, "_out_a"}, 32'(out_a), 32'(ea));
    checkOutput({tag, "_oe_a"},  32'(oe_a),  drive ? 32'h000100 : 32'h0);
    checkOutput({tag, "_out_b"}, 32'(out_b), 32'(eb));
    checkOutput({tag, "_oe_b"},  32'(oe_b),  drive ? 32'hFFFFFF : 32'h0);
    checkOutput({tag, "_out_c"}, 32'(out_c), 32'(ec));
    checkOutput({tag, "_oe_c"},  32'(oe_c),  drive ? 32'h00FF00 : 32'h0);
  endtask

  task automatic checkState(input string tag, input logic busy, input int count);
    checkOutput({tag, "_busy"},  32'(busy_b), 32'(busy));
    checkOutput({tag, "_cnt_a"}, 32'(cnt_a),  32'(count));
    checkOutput({tag, "_cnt_b"}, 32'(cnt_b),  32'(count));
    checkOutput({tag, "_cnt_c"}, 32'(cnt_c),  32'(count % 16));
  endtask

  task automatic sendWord(input logic [23:0] word);
    int n;
    applyStimulus(1'b1, 1'b1, word);
    step();
    applyStimulus(1'b1, 1'b0, word);
    n = 0;
    while (busy_b && n < 10) begin
      step();
      n++;
    end
    checkOutput("send_done", 32'(busy_b), 0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    s_valid_d = 1'b0;
    s_data_d  = 24'h0;
    applyStimulus(1'b0, 1'b0, 24'h0);
    step();
    step();
    checkPads("reset", 24'h0, 1'b0);
    checkState("reset", 1'b0, 0);
    checkOutput("reset_ready", 32'(ready_b), 0);
    rst = 1'b0;

    // Enable held low: valid is ignored.
    applyStimulus(1'b0, 1'b1, 24'hFFFFFF);
    for (int i = 0; i < 5; i++) begin
      step();
      checkOutput("gate_ready", 32'(ready_b), 0);
      checkOutput("gate_oe", 32'(oe_b), 0);
    end
    checkState("gate", 1'b0, 0);

    // Single word.
    applyStimulus(1'b1, 1'b1, 24'hFFFFFF);
    #1 checkOutput("sw_ready_idle", 32'(ready_b), 1);
    step();
    applyStimulus(1'b1, 1'b0, 24'hFFFFFF);
    #1 checkPads("sw_d0", 24'hFFFFFF, 1'b1);
    checkOutput("sw_out_a_lit", 32'(out_a), 32'h000100);
    checkOutput("sw_ready_d0", 32'(ready_b), 0);
    checkState("sw_d0", 1'b1, 0);
    step();
    checkPads("sw_d1", 24'hFFFFFF, 1'b1);
    checkOutput("sw_ready_d1", 32'(ready_b), 1);
    step();
    checkPads("sw_turn", 24'h0, 1'b0);
    checkOutput("sw_ready_turn", 32'(ready_b), 0);
    checkState("sw_turn", 1'b1, 1);
    step();
    checkOutput("sw_ready_idle2", 32'(ready_b), 1);
    checkState("sw_idle", 1'b0, 1);

    // Back-to-back with valid held.
    applyStimulus(1'b1, 1'b1, 24'hA5A5A5);
    step();
    applyStimulus(1'b1, 1'b1, 24'h5A5A5A);
    #1 checkPads("b2b_w0c0", 24'hA5A5A5, 1'b1);
    checkOutput("b2b_ready_w0c0", 32'(ready_b), 0);
    step();
    checkPads("b2b_w0c1", 24'hA5A5A5, 1'b1);
    checkOutput("b2b_ready_w0c1", 32'(ready_b), 1);
    step();
    applyStimulus(1'b1, 1'b0, 24'h5A5A5A);
    #1 checkPads("b2b_w1c0", 24'h5A5A5A, 1'b1);
    checkState("b2b_w1c0", 1'b1, 2);
    step();
    checkPads("b2b_w1c1", 24'h5A5A5A, 1'b1);
    step();
    checkPads("b2b_turn", 24'h0, 1'b0);
    checkState("b2b_turn", 1'b1, 3);
    step();
    checkState("b2b_idle", 1'b0, 3);

    // Enable drops mid-hold; also exercises lane isolation.
    applyStimulus(1'b1, 1'b1, 24'h123456);
    step();
    applyStimulus(1'b0, 1'b0, 24'h123456);
    #1 checkPads("endrop_c0", 24'h123456, 1'b1);
    checkOutput("iso_out_c", 32'(out_c), 32'h0034FF);
    checkOutput("iso_oe_c", 32'(oe_c), 32'h00FF00);
    step();
    checkPads("endrop_c1", 24'h123456, 1'b1);
    checkOutput("endrop_ready", 32'(ready_b), 0);
    step();
    checkPads("endrop_turn", 24'h0, 1'b0);
    checkState("endrop_turn", 1'b1, 4);
    step();
    checkState("endrop_idle", 1'b0, 4);
    checkOutput("endrop_ready_idle", 32'(ready_b), 0);

    // Reset during the first hold cycle.
    applyStimulus(1'b1, 1'b1, 24'hA5A5A5);
    step();
    applyStimulus(1'b1, 1'b0, 24'hA5A5A5);
    #1 checkPads("rstmid_drive", 24'hA5A5A5, 1'b1);
    #1 rst = 1'b1;
    #1 checkPads("rstmid_async", 24'h0, 1'b0);
    checkState("rstmid_async", 1'b0, 0);
    step();
    rst = 1'b0;
    step();
    checkPads("rstmid_after", 24'h0, 1'b0);
    checkState("rstmid_after", 1'b0, 0);
    checkOutput("rstmid_ready", 32'(ready_b), 1);

    // 17 words wrap the 4-bit counter to 1.
    for (int i = 0; i < 17; i++) begin
      sendWord(24'(i * 24'h010203));
    end
    checkState("wrap", 1'b0, 17);
    checkOutput("wrap_c_lit", 32'(cnt_c), 1);

    // Single-cycle hold, no turnaround: back-to-back then straight to idle.
    s_valid_d = 1'b1;
    s_data_d  = 24'h111111;
    #1 checkOutput("h1_ready_idle", 32'(ready_d), 1);
    step();
    s_data_d = 24'h222222;
    #1 checkOutput("h1_out_w0", 32'(out_d), 32'h111111);
    checkOutput("h1_oe_w0", 32'(oe_d), 32'hFFFFFF);
    checkOutput("h1_ready_w0", 32'(ready_d), 1);
    step();
    s_valid_d = 1'b0;
    #1 checkOutput("h1_out_w1", 32'(out_d), 32'h222222);
    checkOutput("h1_oe_w1", 32'(oe_d), 32'hFFFFFF);
    checkOutput("h1_cnt_w1", 32'(cnt_d), 1);
    step();
    checkOutput("h1_out_idle", 32'(out_d), 0);
    checkOutput("h1_oe_idle", 32'(oe_d), 0);
    checkOutput("h1_busy_idle", 32'(busy_d), 0);
    checkOutput("h1_cnt_idle", 32'(cnt_d), 2);
    checkOutput("h1_ready_idle2", 32'(ready_d), 1);

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule
